ins_queue: RTL and testbench

Dual-lane instruction queue between fetch and decode. Accepts up to two fetched instructions per cycle, each with its pc and next_pc. Presents the two oldest entries to decode in show-ahead (first-word-fall-through) form. Decode retires 0, 1 or 2 entries per cycle; a flush port clears all entries on redirect.

---
 rtl/ins_queue.sv | 151 +++++++++++++++
 tb/tb_ins_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ins_queue.sv
// Dual-lane show-ahead instruction queue between fetch and decode.
// Optional same-cycle bypass of write lanes to outputs: define INS_QUEUE_BYPASS_EN.
module ins_queue #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DEPTH_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en0,
  input  logic                   wr_en1,
  input  logic [XLEN-1:0]        pc_in0,
  input  logic [XLEN-1:0]        next_pc_in0,
  input  logic [XLEN-1:0]        instruction_in0,
  input  logic [XLEN-1:0]        pc_in1,
  input  logic [XLEN-1:0]        next_pc_in1,
  input  logic [XLEN-1:0]        instruction_in1,
  input  logic [1:0]             rd_num,
  output logic [XLEN-1:0]        pc_out0,
  output logic [XLEN-1:0]        next_pc_out0,
  output logic [XLEN-1:0]        instruction_out0,
  output logic [XLEN-1:0]        pc_out1,
  output logic [XLEN-1:0]        next_pc_out1,
  output logic [XLEN-1:0]        instruction_out1,
  output logic                   valid0,
  output logic                   valid1,
  output logic                   ins_full,
  output logic                   ins_empty,
  output logic [DEPTH_WIDTH:0]   ins_count
);

`ifdef INS_QUEUE_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  localparam int unsigned CW = DEPTH_WIDTH + 1;

  logic [XLEN-1:0] pc_mem_q  [DEPTH];
  logic [XLEN-1:0] npc_mem_q [DEPTH];
  logic [XLEN-1:0] ins_mem_q [DEPTH];

  logic [DEPTH_WIDTH-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [CW-1:0]          count_q, count_d, free_slots;
  logic [1:0]             rd_req, n_wr, acc, stored_vis, vis, pops, pop_st, pop_wr, n_store;
  logic [2:0]             vis_sum;
  logic                   wr_ok, byp, we0, we1;
  logic [XLEN-1:0]        wa_pc, wa_npc, wa_ins;

  // Virtual order is stored entries followed by accepted writes; bypass exposes writes early.
  always_comb begin
    rd_req     = (rd_num == 2'd3) ? 2'd2 : rd_num;
    n_wr       = wr_en0 ? (wr_en1 ? 2'd2 : 2'd1) : 2'd0;
    free_slots = CW'(DEPTH) - count_q;
    wr_ok      = free_slots >= CW'(n_wr);
    acc        = wr_ok ? n_wr : 2'd0;
    byp        = BypassEn && !flush && (count_q < CW'(2));
    stored_vis = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    vis_sum    = {1'b0, stored_vis} + {1'b0, acc};
    vis        = stored_vis;
    if (byp) vis = (vis_sum > 3'd2) ? 2'd2 : vis_sum[1:0];
    pops       = (rd_req < vis) ? rd_req : vis;
    pop_st     = (pops < stored_vis) ? pops : stored_vis;
    pop_wr     = pops - pop_st;
    n_store    = acc - pop_wr;
  end

  always_comb begin
    head_p1 = head_q + DEPTH_WIDTH'(1);
    tail_p1 = tail_q + DEPTH_WIDTH'(1);
    we0     = !flush && (n_store != 2'd0);
    we1     = !flush && (n_store == 2'd2);
    wa_pc   = pc_in0;
    wa_npc  = next_pc_in0;
    wa_ins  = instruction_in0;
    // Lane 0 already consumed through bypass: lane 1 becomes the first stored write.
    if (pop_wr == 2'd1) begin
      wa_pc  = pc_in1;
      wa_npc = next_pc_in1;
      wa_ins = instruction_in1;
    end
  end

  always_comb begin
    head_d  = head_q + DEPTH_WIDTH'(pop_st);
    tail_d  = tail_q + DEPTH_WIDTH'(n_store);
    count_d = count_q + CW'(acc) - CW'(pops);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) begin
      pc_mem_q[tail_q]  <= wa_pc;
      npc_mem_q[tail_q] <= wa_npc;
      ins_mem_q[tail_q] <= wa_ins;
    end
    if (we1) begin
      pc_mem_q[tail_p1]  <= pc_in1;
      npc_mem_q[tail_p1] <= next_pc_in1;
      ins_mem_q[tail_p1] <= instruction_in1;
    end
  end

  always_comb begin
    pc_out0          = pc_mem_q[head_q];
    next_pc_out0     = npc_mem_q[head_q];
    instruction_out0 = ins_mem_q[head_q];
    pc_out1          = pc_mem_q[head_p1];
    next_pc_out1     = npc_mem_q[head_p1];
    instruction_out1 = ins_mem_q[head_p1];
    if (byp) begin
      if (count_q == '0) begin
        pc_out0          = pc_in0;
        next_pc_out0     = next_pc_in0;
        instruction_out0 = instruction_in0;
        pc_out1          = pc_in1;
        next_pc_out1     = next_pc_in1;
        instruction_out1 = instruction_in1;
      end else begin
        pc_out1          = pc_in0;
        next_pc_out1     = next_pc_in0;
        instruction_out1 = instruction_in0;
      end
    end
  end

  assign valid0    = (vis != 2'd0);
  assign valid1    = (vis == 2'd2);
  assign ins_empty = !valid0;
  assign ins_full  = free_slots < CW'(2);
  assign ins_count = count_q;

endmodule

// File: tb/tb_ins_queue.sv
// Self-checking bench for ins_queue: scoreboard queue of expected entries checked at the outputs.
module tb_ins_queue;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [XLEN-1:0] pc_in0 = '0, next_pc_in0 = '0, instruction_in0 = '0;
  logic [XLEN-1:0] pc_in1 = '0, next_pc_in1 = '0, instruction_in1 = '0;
  logic [1:0] rd_num = '0;
  logic [XLEN-1:0] pc_out0, next_pc_out0, instruction_out0;
  logic [XLEN-1:0] pc_out1, next_pc_out1, instruction_out1;
  logic valid0, valid1, ins_full, ins_empty;
  logic [DW:0] ins_count;

  int checks = 0;
  int errors = 0;
  ent_t q[$];
  logic [31:0] pc_ctr = 32'h100;

  always #5 clk = ~clk;

  ins_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .DEPTH_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_en0(wr_en0), .wr_en1(wr_en1),
    .pc_in0(pc_in0), .next_pc_in0(next_pc_in0), .instruction_in0(instruction_in0),
    .pc_in1(pc_in1), .next_pc_in1(next_pc_in1), .instruction_in1(instruction_in1),
    .rd_num(rd_num),
    .pc_out0(pc_out0), .next_pc_out0(next_pc_out0), .instruction_out0(instruction_out0),
    .pc_out1(pc_out1), .next_pc_out1(next_pc_out1), .instruction_out1(instruction_out1),
    .valid0(valid0), .valid1(valid1), .ins_full(ins_full), .ins_empty(ins_empty),
    .ins_count(ins_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc  = pc;
    e.npc = pc + 32'd4;
    e.ins = pc ^ 32'hDEAD_0000;
    return e;
  endfunction

  // Called at posedge+1; drives one cycle of stimulus, checks mid-cycle, updates model after edge.
  task automatic cycle(input bit w0, input bit w1, input logic [1:0] rd, input bit fl);
    ent_t e0, e1;
    ent_t vq[$];
    int nwr, acc, vis, pops, rs;
    e0 = mk(pc_ctr);
    e1 = mk(pc_ctr + 32'd4);
    wr_en0 = w0; wr_en1 = w1; rd_num = rd; flush = fl;
    pc_in0 = e0.pc; next_pc_in0 = e0.npc; instruction_in0 = e0.ins;
    pc_in1 = e1.pc; next_pc_in1 = e1.npc; instruction_in1 = e1.ins;
    nwr = w0 ? (w1 ? 2 : 1) : 0;
    acc = (DEPTH - q.size() >= nwr) ? nwr : 0;
    pc_ctr += 32'(4 * acc);
    vq = q;
    if (acc >= 1) vq.push_back(e0);
    if (acc == 2) vq.push_back(e1);
    vis = (q.size() > 2) ? 2 : q.size();
`ifdef INS_QUEUE_BYPASS_EN
    if (!fl && q.size() < 2) vis = (vq.size() > 2) ? 2 : vq.size();
`endif
    #4;
    check_eq("ins_count", 64'(ins_count), 64'(q.size()));
    check_eq("valid0", 64'(valid0), 64'(vis >= 1));
    check_eq("valid1", 64'(valid1), 64'(vis >= 2));
    check_eq("ins_empty", 64'(ins_empty), 64'(vis == 0));
    check_eq("ins_full", 64'(ins_full), 64'((DEPTH - q.size()) < 2));
    if (vis >= 1) begin
      check_eq("out0", {pc_out0, next_pc_out0[15:0], instruction_out0[15:0]},
               {vq[0].pc, vq[0].npc[15:0], vq[0].ins[15:0]});
    end
    if (vis >= 2) begin
      check_eq("out1", {pc_out1, next_pc_out1[15:0], instruction_out1[15:0]},
               {vq[1].pc, vq[1].npc[15:0], vq[1].ins[15:0]});
    end
    rs = (rd == 2'd3) ? 2 : int'(rd);
    pops = (rs < vis) ? rs : vis;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      q = vq;
      repeat (pops) void'(q.pop_front());
    end
  endtask

  task automatic async_reset_check();
    wr_en0 = 0; wr_en1 = 0; rd_num = 0; flush = 0;
    #1 reset = 1'b0;
    #1;
    check_eq("rst_count", 64'(ins_count), 64'd0);
    check_eq("rst_empty", 64'(ins_empty), 64'd1);
    check_eq("rst_full", 64'(ins_full), 64'd0);
    check_eq("rst_valid", {valid0, valid1}, 64'd0);
    q.delete();
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check_eq("init_count", 64'(ins_count), 64'd0);
    check_eq("init_empty", 64'(ins_empty), 64'd1);
    #4 reset = 1'b1;
    @(posedge clk);
    #1;
    // Dual push then single pops.
    pc_ctr = 32'h100;
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    repeat (2) cycle(0, 0, 2, 0);
    // Fill, then pop 2 / push 2 across the wrap (first one rejected at full).
    repeat (4) cycle(1, 1, 0, 0);
    repeat (10) cycle(1, 1, 2, 0);
    // Drain to one, over-pop, refill to 7 and overflow.
    cycle(0, 0, 2, 0);
    cycle(0, 0, 2, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 2, 0);
    cycle(0, 0, 3, 0);
    repeat (3) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 2, 0);
    // Flush priority at count 5.
    cycle(1, 1, 2, 1);
    cycle(0, 0, 0, 0);
    // Bypass stimulus from empty; wr_en1 alone ignored.
    pc_ctr = 32'h200;
    cycle(1, 1, 1, 0);
    cycle(1, 1, 2, 0);
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 0, 2, 0);
    // Mid-stream async reset with 5 entries.
    repeat (2) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    async_reset_check();
    cycle(0, 0, 0, 0);
    repeat (300) begin
      cycle(($urandom % 4) != 0, $urandom % 2, 2'($urandom % 4), ($urandom % 32) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
